// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//
// Clocked, parameterizable full subtractor: {Bout, Diff} = A - B - Bin on
// unsigned WIDTH-bit operands. The difference is built from a ripple chain
// of one-bit borrow cells, from LSB to MSB, and the result is registered.
//
// Parameters:
//   WIDTH  operand / difference width in bits (>= 1), default 1
//
// Ports:
//   clk    in   1      clock, all state updates on the rising edge
//   rst_n  in   1      synchronous active-low reset, clears all registers
//   A      in   WIDTH  minuend, unsigned
//   B      in   WIDTH  subtrahend, unsigned
//   Bin    in   1      borrow-in, weight 1
//   Diff   out  WIDTH  registered (A - B - Bin) mod 2^WIDTH
//   Bout   out  1      registered borrow-out, 1 when A < B + Bin
//
// Build option:
//   FULLSUBTRACTOR_INPUT_REG_EN  when defined, A/B/Bin are registered
//                                before the subtractor (latency 2 instead
//                                of 1). The arithmetic result is the same.
// ---------------------------------------------------------------------------
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  // Operands that feed the borrow chain (registered or direct).
  logic [WIDTH-1:0] a_core;
  logic [WIDTH-1:0] b_core;
  logic             bin_core;

`ifdef FULLSUBTRACTOR_INPUT_REG_EN
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             bin_reg;

  // The input stage clears under reset too, so the first result after
  // release is computed from zeros and no pre-reset operand leaks out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      bin_reg <= 1'b0;
    end else begin
      a_reg   <= A;
      b_reg   <= B;
      bin_reg <= Bin;
    end
  end

  assign a_core   = a_reg;
  assign b_core   = b_reg;
  assign bin_core = bin_reg;
`else
  assign a_core   = A;
  assign b_core   = B;
  assign bin_core = Bin;
`endif

  // borrow[i] is the borrow into cell i; borrow[WIDTH] leaves the MSB.
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_next;

  assign borrow[0] = bin_core;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign diff_next[gi]  = a_core[gi] ^ b_core[gi] ^ borrow[gi];
      // A borrow leaves the cell when the subtrahend side (B_i + b_i)
      // exceeds A_i.
      assign borrow[gi+1]   = (~a_core[gi] & b_core[gi])
                            | (~a_core[gi] & borrow[gi])
                            | ( b_core[gi] & borrow[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_reg <= '0;
      bout_reg <= 1'b0;
    end else begin
      diff_reg <= diff_next;
      bout_reg <= borrow[WIDTH];
    end
  end

  assign Diff = diff_reg;
  assign Bout = bout_reg;

endmodule

// File: tb/tb_full_subtractor.sv
module tb_full_subtractor;

`ifdef FULLSUBTRACTOR_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        a1, b1, bin;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        d1;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic        bo1, bo8, bo16;

  int total_checks;
  int passed_checks;

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Bin(bin), .Diff(d1), .Bout(bo1)
  );
  full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Bin(bin), .Diff(d8), .Bout(bo8)
  );
  full_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Bin(bin), .Diff(d16), .Bout(bo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] a, input logic [15:0] b, input logic bi);
    a1  = a[0];
    b1  = b[0];
    a8  = a[7:0];
    b8  = b[7:0];
    a16 = a;
    b16 = b;
    bin = bi;
  endtask

  task automatic check(input string name, input int w,
                       input logic [15:0] exp_d, input logic exp_b);
    logic [15:0] act_d;
    logic        act_b;
    case (w)
      1:       begin act_d = {15'd0, d1}; act_b = bo1; end
      8:       begin act_d = {8'd0, d8};  act_b = bo8; end
      default: begin act_d = d16;         act_b = bo16; end
    endcase
    total_checks++;
    if (act_d !== exp_d || act_b !== exp_b)
      $display("FAIL %s w=%0d: got Diff=%h Bout=%b, expected Diff=%h Bout=%b",
               name, w, act_d, act_b, exp_d, exp_b);
    else begin
      passed_checks++;
      $display("ok   %s w=%0d: Diff=%h Bout=%b", name, w, act_d, act_b);
    end
  endtask

  // Arithmetic reference: (WIDTH+1)-bit subtraction, bit 16 is the borrow.
  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic bi);
    return {1'b0, a} - {1'b0, b} - {16'd0, bi};
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic        rbin;
    logic [15:0] m_in_a, m_in_b;
    logic        m_in_bin;
    logic [16:0] m_out;

    total_checks  = 0;
    passed_checks = 0;

    tbl[0]  = '{1, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0};
    tbl[1]  = '{1, 16'h1, 16'h0, 1'b0, 16'h1, 1'b0};
    tbl[2]  = '{1, 16'h0, 16'h1, 1'b0, 16'h1, 1'b1};
    tbl[3]  = '{1, 16'h1, 16'h1, 1'b0, 16'h0, 1'b0};
    tbl[4]  = '{1, 16'h0, 16'h0, 1'b1, 16'h1, 1'b1};
    tbl[5]  = '{1, 16'h1, 16'h0, 1'b1, 16'h0, 1'b0};
    tbl[6]  = '{1, 16'h0, 16'h1, 1'b1, 16'h0, 1'b1};
    tbl[7]  = '{1, 16'h1, 16'h1, 1'b1, 16'h1, 1'b1};
    tbl[8]  = '{8, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1};
    tbl[9]  = '{8, 16'hFF, 16'h01, 1'b0, 16'hFE, 1'b0};
    tbl[10] = '{8, 16'h80, 16'h00, 1'b1, 16'h7F, 1'b0};
    tbl[11] = '{8, 16'h00, 16'hFF, 1'b1, 16'h00, 1'b1};
    tbl[12] = '{8, 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1};
    tbl[13] = '{8, 16'hFF, 16'h00, 1'b0, 16'hFF, 1'b0};
    tbl[14] = '{16, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    tbl[15] = '{16, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[16] = '{16, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    tbl[17] = '{16, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0};

    // Reset: held for two edges with A=1, B=0, Bin=0.
    rst_n = 1'b0;
    set_in(16'h1, 16'h0, 1'b0);
    tick();
    tick();
    check("reset_hold", 1, 16'h0, 1'b0);
    rst_n = 1'b1;
    tick();
    if (LAT == 2) begin
      check("reset_release_edge1", 1, 16'h0, 1'b0);
      tick();
    end
    check("reset_release", 1, 16'h1, 1'b0);

    // Table vectors, each held for the full latency.
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].a, tbl[i].b, tbl[i].bin);
      for (int k = 0; k < LAT; k++) tick();
      check($sformatf("table[%0d]", i), tbl[i].w, tbl[i].diff, tbl[i].bout);
    end

    // Exhaustive WIDTH=1 streamed one vector per cycle.
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      if (i < 8) set_in(tbl[i].a, tbl[i].b, tbl[i].bin);
      tick();
      if (i >= LAT - 1)
        check($sformatf("stream1[%0d]", i - LAT + 1), 1,
              tbl[i-LAT+1].diff, tbl[i-LAT+1].bout);
    end

    // Randomized WIDTH=16 stream with a one-edge reset in the middle.
    rst_n = 1'b0;
    set_in(16'hBEEF, 16'h1234, 1'b1);
    tick();
    check("rand_start_reset", 16, 16'h0, 1'b0);
    m_in_a = '0; m_in_b = '0; m_in_bin = 1'b0; m_out = '0;
    for (int i = 0; i < 10000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      rst_n = (i == 5000) ? 1'b0 : 1'b1;
      set_in(ra, rb, rbin);
      tick();
      if (!rst_n) begin
        m_in_a = '0; m_in_b = '0; m_in_bin = 1'b0; m_out = '0;
      end else if (LAT == 2) begin
        m_out    = ref16(m_in_a, m_in_b, m_in_bin);
        m_in_a   = ra;
        m_in_b   = rb;
        m_in_bin = rbin;
      end else begin
        m_out = ref16(ra, rb, rbin);
      end
      check($sformatf("rand16[%0d]", i), 16, m_out[15:0], m_out[16]);
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
